inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 114 +++++++++++
 tb/tb_inst_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem read, result held until the datapath consumes it.
// Latency: request on the edge after IDLE, instruction registered on rvalid; holds while dp_ready=0.
module inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] curr_pc,
    input  logic        flush,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    input  logic        dp_ready,
    output logic        inst_ready,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q;
    logic        imem_ren_q;
    logic [31:0] imem_addr_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        fetch_err_q;
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;

    assign fetch_cnt_d = fetch_cnt_q + 32'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            imem_ren_q   <= 1'b0;
            imem_addr_q  <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            fetch_err_q  <= 1'b0;
            fetch_cnt_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!flush) begin
                        if (curr_pc[1:0] == 2'b00) begin
                            imem_addr_q <= curr_pc;
                            imem_ren_q  <= 1'b1;
                            state_q     <= WAIT;
                        end else begin
                            // Misaligned PC never reaches memory; a NOP carries the error flag.
                            inst_q       <= NOP_INST;
                            inst_pc_q    <= curr_pc;
                            fetch_err_q  <= 1'b1;
                            inst_valid_q <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        // A response coinciding with flush retires the read right here.
                        imem_ren_q <= 1'b0;
                        state_q    <= imem_rvalid ? IDLE : DROP;
                    end else if (imem_rvalid) begin
                        inst_q       <= imem_rdata;
                        inst_pc_q    <= imem_addr_q;
                        fetch_err_q  <= 1'b0;
                        inst_valid_q <= 1'b1;
                        imem_ren_q   <= 1'b0;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        inst_valid_q <= 1'b0;
                        fetch_err_q  <= 1'b0;
                        state_q      <= IDLE;
                    end else if (dp_ready) begin
                        inst_valid_q <= 1'b0;
                        fetch_cnt_q  <= fetch_cnt_d;
                        state_q      <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_ready = (state_q == HOLD) & dp_ready & ~flush;
    assign imem_ren   = imem_ren_q;
    assign imem_addr  = imem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: PC-stage driver, latency-randomised memory, output monitor.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [31:0] curr_pc = 32'd0;
    logic        flush = 1'b0;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_rvalid = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        dp_ready = 1'b0;
    logic        inst_ready;
    logic [31:0] fetch_cnt;

    inst_fetch dut (
        .clk        (clk),
        .nrst       (nrst),
        .curr_pc    (curr_pc),
        .flush      (flush),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_rvalid(imem_rvalid),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fetch_err  (fetch_err),
        .dp_ready   (dp_ready),
        .inst_ready (inst_ready),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
    } ex_t;

    ex_t         exp_q[$];
    logic [31:0] pc_src[$];
    int          checks = 0;
    int          errors = 0;
    int          accepts = 0;
    logic [31:0] model_cnt = 32'd0;
    bit          acc_seen = 1'b0;
    int          lat_fix = 0;
    bit          rand_lat = 1'b0;
    bit          spur_en = 1'b0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        if (a == 32'h0000_0200) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
    endfunction

    // The PC stage presents a new PC; the next accepted instruction must describe it.
    task automatic new_pc();
        logic [31:0] p;
        ex_t         e;
        if (pc_src.size() > 0) begin
            p = pc_src.pop_front();
        end else begin
            p = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 5) == 0) p[1:0] = 2'($urandom_range(1, 3));
        end
        curr_pc = p;
        e.pc    = p;
        e.err   = (p[1:0] != 2'b00);
        e.word  = e.err ? 32'h0000_0013 : mem_word(p);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic fl, input logic dr);
        @(posedge clk);
        #1;
        if (flush) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            new_pc();
        end else if (acc_seen) begin
            new_pc();
        end
        acc_seen = 1'b0;
        flush    = fl;
        dp_ready = dr;
    endtask

    task automatic run(input int n, input logic dr);
        repeat (n) cycle(1'b0, dr);
    endtask

    task automatic wait_valid(input int max, input logic dr);
        int k = 0;
        while (!inst_valid && k < max) begin
            cycle(1'b0, dr);
            k++;
        end
        chk1("wait_valid_timeout", inst_valid, 1'b1);
    endtask

    task automatic wait_ren(input int max);
        int k = 0;
        while (!imem_ren && k < max) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        chk1("wait_ren_timeout", imem_ren, 1'b1);
    endtask

    task automatic do_reset(input logic [31:0] pc);
        nrst = 1'b0;
        #1;
        chk1("rst_ren", imem_ren, 1'b0);
        chk32("rst_addr", imem_addr, 32'd0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk32("rst_inst", inst, 32'd0);
        chk32("rst_inst_pc", inst_pc, 32'd0);
        chk1("rst_err", fetch_err, 1'b0);
        chk32("rst_cnt", fetch_cnt, 32'd0);
        chk1("rst_inst_ready", inst_ready, 1'b0);
        exp_q.delete();
        pc_src.delete();
        model_cnt = 32'd0;
        acc_seen  = 1'b0;
        flush     = 1'b0;
        pc_src.push_back(pc);
        new_pc();
        @(negedge clk);
        #2;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk1("first_req_ren", imem_ren, 1'b1);
        chk32("first_req_addr", imem_addr, pc);
    endtask

    // Memory: one read per request, configurable latency, dropped on reset,
    // plus stray strobes while no read is outstanding.
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_l = 32'd0;

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (!nrst) begin
            mem_busy = 1'b0;
        end else begin
            if (!mem_busy && imem_ren) begin
                mem_busy   = 1'b1;
                mem_cnt    = rand_lat ? $urandom_range(0, 3) : lat_fix;
                mem_addr_l = imem_addr;
            end
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_addr_l);
                    mem_busy    = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if (spur_en && !imem_ren && $urandom_range(0, 7) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_0000 | ($urandom & 32'hFFFF);
            end
        end
    end

    always @(negedge clk) begin : monitor
        ex_t e;
        if (nrst) begin
            chk32("fetch_cnt", fetch_cnt, model_cnt);
            if (!dp_ready || flush) chk1("inst_ready_blocked", inst_ready, 1'b0);
            if (exp_q.size() == 0) begin
                if (imem_ren || inst_valid) chk1("activity_without_pc", 1'b1, 1'b0);
            end else begin
                e = exp_q[0];
                if (imem_ren) begin
                    chk1("ren_on_misaligned", imem_ren, !e.err);
                    chk32("imem_addr", imem_addr, e.pc);
                end
                if (inst_valid) begin
                    chk32("inst", inst, e.word);
                    chk32("inst_pc", inst_pc, e.pc);
                    chk1("fetch_err", fetch_err, e.err);
                end
            end
            if (inst_ready) begin
                chk1("accept_valid", inst_valid, 1'b1);
                acc_seen = 1'b1;
                model_cnt++;
                accepts++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int a0;
        dp_ready = 1'b1;
        #1;
        // Zero-wait fetch of 0x100, then a misaligned PC 0x102.
        do_reset(32'h0000_0100);
        pc_src.push_back(32'h0000_0102);
        lat_fix = 0;
        run(8, 1'b1);

        // Slow memory with datapath stall in HOLD: exactly one consume pulse.
        lat_fix = 5;
        run(4, 1'b1);
        wait_valid(20, 1'b0);
        a0 = accepts;
        run(3, 1'b0);
        run(1, 1'b1);
        run(3, 1'b0);
        chk32("single_accept", 32'(accepts - a0), 32'd1);

        // Counter wrap.
        wait_valid(20, 1'b0);
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        run(1, 1'b1);
        run(2, 1'b0);
        chk32("cnt_wrap", fetch_cnt, 32'd0);

        // Flush during WAIT: the late 0x12345678 response must be discarded.
        do_reset(32'h0000_0200);
        pc_src.push_back(32'h0000_0300);
        lat_fix = 2;
        cycle(1'b1, 1'b1);
        run(10, 1'b1);
        chk32("cnt_after_flush", fetch_cnt, model_cnt);

        // Reset asserted while a read is outstanding.
        lat_fix = 5;
        run(4, 1'b1);
        wait_ren(20);
        cycle(1'b0, 1'b1);
        do_reset(32'h0000_0440);
        run(10, 1'b1);

        // Randomised traffic with flushes, stalls and stray strobes.
        rand_lat = 1'b1;
        spur_en  = 1'b1;
        a0 = accepts;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end
        chk1("progress", (accepts - a0) > 100, 1'b1);
        run(3, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
